// File: rtl/pkg_decoder_3lxnpc.sv
// Shared leg-state enums plus gate-feedback codes and the encoder FSM types.
package PKG_decoder_3lxnpc;

  localparam int unsigned TDELAY_WIDTH = 8;
  localparam int unsigned GATE_W       = 6;

  typedef enum logic [1:0] {
    NOOUT = 2'd0,
    NPC   = 2'd1,
    NPP   = 2'd2,
    ANPC  = 2'd3
  } _npctypes_t;

  typedef enum logic [2:0] {
    ANPC_P   = 3'd0,
    ANPC_ZU2 = 3'd1,
    ANPC_ZU1 = 3'd2,
    ANPC_ZL1 = 3'd3,
    ANPC_ZL2 = 3'd4,
    ANPC_N   = 3'd5
  } _statesanpc_t;

  typedef enum logic [1:0] {
    NPC_PP = 2'd0,
    NPC_ZZ = 2'd1,
    NPC_NN = 2'd2
  } _statesnpc_t;

  localparam logic [5:0] G_ANPC_P   = 6'b100011;
  localparam logic [5:0] G_ANPC_ZU2 = 6'b010010;
  localparam logic [5:0] G_ANPC_ZU1 = 6'b011010;
  localparam logic [5:0] G_ANPC_ZL1 = 6'b100101;
  localparam logic [5:0] G_ANPC_ZL2 = 6'b100100;
  localparam logic [5:0] G_ANPC_N   = 6'b011100;
  localparam logic [3:0] G_NPC_PP   = 4'b0011;
  localparam logic [3:0] G_NPC_ZZ   = 4'b0110;
  localparam logic [3:0] G_NPC_NN   = 4'b1100;
  localparam logic [5:0] G_BLANK    = 6'b000000;

  typedef enum logic [1:0] {
    ENC_IDLE   = 2'd0,
    ENC_LOCKED = 2'd1,
    ENC_DEAD   = 2'd2,
    ENC_FAULT  = 2'd3
  } enc_state_t;

  typedef struct packed {
    logic         valid;
    logic         blank;
    _statesanpc_t anpc;
    _statesnpc_t  npc;
  } fb_dec_t;

  // Classify a feedback code for the given topology; neither valid nor blank means illegal.
  function automatic fb_dec_t decode_fb(input _npctypes_t t, input logic [5:0] g);
    fb_dec_t d;
    d.valid = 1'b0;
    d.blank = 1'b0;
    d.anpc  = ANPC_P;
    d.npc   = NPC_PP;
    if (t == NOOUT) begin
      d.blank = 1'b1;
    end else if (t == ANPC) begin
      case (g)
        G_ANPC_P:   begin d.valid = 1'b1; d.anpc = ANPC_P;   end
        G_ANPC_ZU2: begin d.valid = 1'b1; d.anpc = ANPC_ZU2; end
        G_ANPC_ZU1: begin d.valid = 1'b1; d.anpc = ANPC_ZU1; end
        G_ANPC_ZL1: begin d.valid = 1'b1; d.anpc = ANPC_ZL1; end
        G_ANPC_ZL2: begin d.valid = 1'b1; d.anpc = ANPC_ZL2; end
        G_ANPC_N:   begin d.valid = 1'b1; d.anpc = ANPC_N;   end
        G_BLANK:    d.blank = 1'b1;
        default:    d.valid = 1'b0;
      endcase
    end else begin
      case (g[3:0])
        G_NPC_PP:      begin d.valid = 1'b1; d.npc = NPC_PP; end
        G_NPC_ZZ:      begin d.valid = 1'b1; d.npc = NPC_ZZ; end
        G_NPC_NN:      begin d.valid = 1'b1; d.npc = NPC_NN; end
        G_BLANK[3:0]:  d.blank = 1'b1;
        default:       d.valid = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/encoder_3lxnpc_fb_sync_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter on the gate feedback bus.
module fb_sync_filter #(
  parameter int unsigned W           = 6,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] code_c,
  output logic         accept_c
);

  localparam int unsigned CW = 4;

  logic [W-1:0]  meta;
  logic [W-1:0]  sync;
  logic [W-1:0]  cand;
  logic [CW-1:0] run;

  // run holds how many consecutive samples of cand have already been seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      cand <= '0;
      run  <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      if (sync != cand) begin
        cand <= sync;
        run  <= CW'(1);
      end else if (run < CW'(FILT_CYCLES)) begin
        run <= run + CW'(1);
      end
    end
  end

  // Strobe on exactly the FILT_CYCLES-th matching sample of a run.
  always_comb begin
    code_c = sync;
    if (sync != cand) accept_c = (FILT_CYCLES == 1);
    else              accept_c = (run == CW'(FILT_CYCLES - 1));
  end

endmodule

// File: rtl/encoder_3lxnpc.sv
// Gate-feedback encoder for one 3L-NPC/NPP/ANPC leg: decodes accepted gate codes,
// measures commutation dead time and latches illegal-pattern faults.
module encoder_3lxnpc
  import PKG_decoder_3lxnpc::*;
#(
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned TDW         = TDELAY_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  _npctypes_t     npc_type,
  input  logic [5:0]     g_fb,
  input  logic [TDW-1:0] tdelay_min,
  input  logic           fault_clr,
  output _statesanpc_t   state_anpc,
  output _statesnpc_t    state_npc,
  output logic           state_valid,
  output logic [TDW-1:0] tdead_meas,
  output logic           tdead_vld,
  output logic           dt_err,
  output logic           fault,
  output logic [5:0]     fault_code,
  output logic [15:0]    comm_cnt
);

  localparam logic [TDW-1:0] DCNT_MAX = '1;

  logic [5:0] code_c;
  logic       accept_c;
  fb_dec_t    dec_c;
  logic       differs_c;
  logic       illegal_c;
  logic       type_chg_c;

  enc_state_t     state, state_nxt;
  _npctypes_t     npc_q;
  logic [TDW-1:0] dcnt, dcnt_nxt;
  _statesanpc_t   state_anpc_nxt;
  _statesnpc_t    state_npc_nxt;
  logic           state_valid_nxt;
  logic [TDW-1:0] tdead_meas_nxt;
  logic           tdead_vld_nxt;
  logic           dt_err_nxt;
  logic           fault_nxt;
  logic [5:0]     fault_code_nxt;
  logic [15:0]    comm_cnt_nxt;

  fb_sync_filter #(
    .W           (GATE_W),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_filt (
    .clk      (clk),
    .rst      (rst),
    .d        (g_fb),
    .code_c   (code_c),
    .accept_c (accept_c)
  );

  assign dec_c      = decode_fb(npc_type, code_c);
  assign illegal_c  = accept_c && !dec_c.valid && !dec_c.blank;
  assign type_chg_c = (npc_type != npc_q);
  assign differs_c  = (npc_type == ANPC) ? (dec_c.anpc != state_anpc)
                                         : (dec_c.npc != state_npc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ENC_IDLE;
      npc_q       <= NOOUT;
      dcnt        <= '0;
      state_anpc  <= ANPC_P;
      state_npc   <= NPC_PP;
      state_valid <= 1'b0;
      tdead_meas  <= '0;
      tdead_vld   <= 1'b0;
      dt_err      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
      comm_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      npc_q       <= npc_type;
      dcnt        <= dcnt_nxt;
      state_anpc  <= state_anpc_nxt;
      state_npc   <= state_npc_nxt;
      state_valid <= state_valid_nxt;
      tdead_meas  <= tdead_meas_nxt;
      tdead_vld   <= tdead_vld_nxt;
      dt_err      <= dt_err_nxt;
      fault       <= fault_nxt;
      fault_code  <= fault_code_nxt;
      comm_cnt    <= comm_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    dcnt_nxt        = dcnt;
    state_anpc_nxt  = state_anpc;
    state_npc_nxt   = state_npc;
    state_valid_nxt = state_valid;
    tdead_meas_nxt  = tdead_meas;
    tdead_vld_nxt   = 1'b0;
    dt_err_nxt      = 1'b0;
    fault_nxt       = fault;
    fault_code_nxt  = fault_code;
    comm_cnt_nxt    = comm_cnt;

    if (state == ENC_DEAD && dcnt != DCNT_MAX) dcnt_nxt = dcnt + TDW'(1);

    // Topology change or NoOut drops the leg to IDLE unless a fault is pending.
    if (state != ENC_FAULT && (type_chg_c || npc_type == NOOUT)) begin
      state_nxt       = ENC_IDLE;
      state_valid_nxt = 1'b0;
      if (npc_type == NOOUT) begin
        state_anpc_nxt = ANPC_P;
        state_npc_nxt  = NPC_PP;
        tdead_meas_nxt = '0;
        comm_cnt_nxt   = '0;
      end
    end else if (illegal_c && (state != ENC_FAULT || fault_clr)) begin
      state_nxt       = ENC_FAULT;
      state_valid_nxt = 1'b0;
      fault_nxt       = 1'b1;
      fault_code_nxt  = code_c;
    end else begin
      case (state)
        ENC_IDLE: begin
          if (accept_c && dec_c.valid) begin
            state_nxt       = ENC_LOCKED;
            state_valid_nxt = 1'b1;
            if (npc_type == ANPC) state_anpc_nxt = dec_c.anpc;
            else                  state_npc_nxt  = dec_c.npc;
          end
        end
        ENC_LOCKED: begin
          if (accept_c && dec_c.blank) begin
            state_nxt       = ENC_DEAD;
            state_valid_nxt = 1'b0;
            dcnt_nxt        = TDW'(1);
          end else if (accept_c && dec_c.valid && differs_c) begin
            tdead_meas_nxt = '0;
            tdead_vld_nxt  = 1'b1;
            dt_err_nxt     = (tdelay_min != '0);
            comm_cnt_nxt   = comm_cnt + 16'd1;
            if (npc_type == ANPC) state_anpc_nxt = dec_c.anpc;
            else                  state_npc_nxt  = dec_c.npc;
          end
        end
        ENC_DEAD: begin
          if (accept_c && dec_c.valid) begin
            state_nxt       = ENC_LOCKED;
            state_valid_nxt = 1'b1;
            tdead_meas_nxt  = dcnt;
            tdead_vld_nxt   = 1'b1;
            dt_err_nxt      = (dcnt < tdelay_min);
            comm_cnt_nxt    = comm_cnt + 16'd1;
            if (npc_type == ANPC) state_anpc_nxt = dec_c.anpc;
            else                  state_npc_nxt  = dec_c.npc;
          end
        end
        ENC_FAULT: begin
          if (fault_clr) begin
            state_nxt = ENC_IDLE;
            fault_nxt = 1'b0;
          end
        end
        default: state_nxt = ENC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_3lxnpc.sv
// Randomized bench for encoder_3lxnpc against a timestamp-based leg model, plus directed scenarios.
module tb_encoder_3lxnpc;
  import PKG_decoder_3lxnpc::*;

  localparam int FILT = 4;

  logic         clk = 1'b0;
  logic         rst;
  _npctypes_t   npc_type;
  logic [5:0]   g_fb;
  logic [7:0]   tdelay_min;
  logic         fault_clr;
  _statesanpc_t state_anpc;
  _statesnpc_t  state_npc;
  logic         state_valid;
  logic [7:0]   tdead_meas;
  logic         tdead_vld;
  logic         dt_err;
  logic         fault;
  logic [5:0]   fault_code;
  logic [15:0]  comm_cnt;

  encoder_3lxnpc #(.FILT_CYCLES(FILT), .TDW(8)) dut (
    .clk(clk), .rst(rst), .npc_type(npc_type), .g_fb(g_fb),
    .tdelay_min(tdelay_min), .fault_clr(fault_clr),
    .state_anpc(state_anpc), .state_npc(state_npc), .state_valid(state_valid),
    .tdead_meas(tdead_meas), .tdead_vld(tdead_vld), .dt_err(dt_err),
    .fault(fault), .fault_code(fault_code), .comm_cnt(comm_cnt)
  );

  always #5 clk = ~clk;

  logic [5:0] anpc_tab [6] = '{6'b100011, 6'b010010, 6'b011010, 6'b100101, 6'b100100, 6'b011100};
  logic [3:0] npc_tab  [3] = '{4'b0011, 4'b0110, 4'b1100};

  int n_vec = 0;
  int n_err = 0;
  int n_vld = 0;
  int n_dte = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: filter as run lengths of the 2-cycle delayed input, dead time as timestamp difference.
  logic [5:0] m_sq1, m_sq2, m_rv;
  int m_rlen, m_prev_type, m_blank_at, cyc;
  bit m_fault;
  int e_anpc, e_npc, e_valid, e_meas, e_vld, e_dterr, e_fault, e_fcode, e_comm;

  // 0 = blank, 1 = valid (idx = table position), 2 = illegal
  function automatic int classify(input int t, input logic [5:0] g, output int idx);
    idx = 0;
    if (t == 0) return 0;
    if (t == 3) begin
      if (g == 6'd0) return 0;
      for (int i = 0; i < 6; i++) if (g == anpc_tab[i]) begin idx = i; return 1; end
      return 2;
    end
    if (g[3:0] == 4'd0) return 0;
    for (int i = 0; i < 3; i++) if (g[3:0] == npc_tab[i]) begin idx = i; return 1; end
    return 2;
  endfunction

  task automatic model_reset();
    m_sq1 = 0; m_sq2 = 0; m_rv = 0; m_rlen = 0; m_prev_type = 0; m_blank_at = -1; m_fault = 0;
    e_anpc = 0; e_npc = 0; e_valid = 0; e_meas = 0; e_vld = 0; e_dterr = 0;
    e_fault = 0; e_fcode = 0; e_comm = 0;
  endtask

  task automatic model_step();
    logic [5:0] v;
    int c, idx, meas, cur;
    bit acc, chg, comm;
    cyc++;
    if (rst) begin model_reset(); return; end
    e_vld = 0; e_dterr = 0;
    v = m_sq2; m_sq2 = m_sq1; m_sq1 = g_fb;
    if (v == m_rv) m_rlen++; else begin m_rv = v; m_rlen = 1; end
    acc = (m_rlen == FILT);
    chg = (int'(npc_type) != m_prev_type);
    m_prev_type = int'(npc_type);
    c = classify(int'(npc_type), v, idx);
    if (!m_fault && (chg || npc_type == NOOUT)) begin
      e_valid = 0; m_blank_at = -1;
      if (npc_type == NOOUT) begin e_anpc = 0; e_npc = 0; e_meas = 0; e_comm = 0; end
    end else if (acc && c == 2 && (!m_fault || fault_clr)) begin
      m_fault = 1; e_fault = 1; e_fcode = int'(v); e_valid = 0; m_blank_at = -1;
    end else if (m_fault) begin
      if (fault_clr) begin m_fault = 0; e_fault = 0; end
    end else if (acc && c == 0) begin
      if (e_valid != 0) begin m_blank_at = cyc; e_valid = 0; end
    end else if (acc && c == 1) begin
      cur = (npc_type == ANPC) ? e_anpc : e_npc;
      comm = 0; meas = 0;
      if (m_blank_at >= 0) begin
        comm = 1; meas = cyc - m_blank_at;
        if (meas > 255) meas = 255;
      end else if (e_valid != 0 && idx != cur) begin
        comm = 1;
      end
      if (comm) begin
        e_meas = meas; e_vld = 1; e_dterr = (meas < int'(tdelay_min)) ? 1 : 0;
        e_comm = (e_comm + 1) % 65536;
      end
      if (npc_type == ANPC) e_anpc = idx; else e_npc = idx;
      e_valid = 1; m_blank_at = -1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("state_anpc",  32'(state_anpc),  32'(e_anpc));
    check_val("state_npc",   32'(state_npc),   32'(e_npc));
    check_val("state_valid", 32'(state_valid), 32'(e_valid));
    check_val("tdead_meas",  32'(tdead_meas),  32'(e_meas));
    check_val("tdead_vld",   32'(tdead_vld),   32'(e_vld));
    check_val("dt_err",      32'(dt_err),      32'(e_dterr));
    check_val("fault",       32'(fault),       32'(e_fault));
    check_val("fault_code",  32'(fault_code),  32'(e_fcode));
    check_val("comm_cnt",    32'(comm_cnt),    32'(e_comm));
    if (tdead_vld) n_vld++;
    if (dt_err) n_dte++;
  endtask

  task automatic hold(input logic [5:0] code, input int n);
    g_fb = code;
    repeat (n) cycle();
  endtask

  initial begin
    int r, len, t;
    logic [5:0] code;
    cyc = 0;
    model_reset();
    rst = 1'b1; npc_type = ANPC; g_fb = 6'b100011; tdelay_min = 8'd10; fault_clr = 1'b0;
    cycle(); cycle();
    check_val("rst_anpc",  32'(state_anpc),  32'(0));
    check_val("rst_valid", 32'(state_valid), 32'(0));
    check_val("rst_comm",  32'(comm_cnt),    32'(0));
    rst = 1'b0;

    // P -> 12-cycle blank -> Z_U2
    hold(6'b100011, 10);
    n_vld = 0; n_dte = 0;
    hold(6'b000000, 12);
    hold(6'b010010, 10);
    check_val("tp1_meas",  32'(tdead_meas), 32'(12));
    check_val("tp1_nvld",  32'(n_vld),      32'(1));
    check_val("tp1_ndte",  32'(n_dte),      32'(0));
    check_val("tp1_state", 32'(state_anpc), 32'(ANPC_ZU2));
    check_val("tp1_comm",  32'(comm_cnt),   32'(1));

    // short blank of 6
    n_dte = 0;
    hold(6'b000000, 6);
    hold(6'b011010, 10);
    check_val("tp2_meas", 32'(tdead_meas), 32'(6));
    check_val("tp2_ndte", 32'(n_dte),      32'(1));

    // 2-cycle blank is filtered: direct transition
    n_dte = 0;
    hold(6'b000000, 2);
    hold(6'b100101, 10);
    check_val("tp3_meas",  32'(tdead_meas), 32'(0));
    check_val("tp3_ndte",  32'(n_dte),      32'(1));
    check_val("tp3_state", 32'(state_anpc), 32'(ANPC_ZL1));

    // 3-cycle glitch to all-ones
    hold(6'h3F, 3);
    hold(6'b100101, 10);
    check_val("tp4_glitch_fault", 32'(fault), 32'(0));

    // NPC mode: stable illegal, clear, reacquire PP
    npc_type = NPC;
    hold(6'h03, 10);
    hold(6'h3F, 10);
    check_val("tp4_fault", 32'(fault),      32'(1));
    check_val("tp4_code",  32'(fault_code), 32'(6'h3F));
    fault_clr = 1'b1; cycle(); fault_clr = 1'b0;
    check_val("tp4_clr_fault", 32'(fault), 32'(0));
    g_fb = 6'h03;
    repeat (5) cycle();
    check_val("tp4_pp_early", 32'(state_valid), 32'(0));
    cycle();
    check_val("tp4_pp_lock", 32'(state_valid), 32'(1));
    check_val("tp4_pp_state", 32'(state_npc), 32'(NPC_PP));

    // 300-cycle blank saturates
    hold(6'h00, 300);
    hold(6'h0C, 10);
    check_val("tp5_meas",  32'(tdead_meas), 32'(255));
    check_val("tp5_state", 32'(state_npc),  32'(NPC_NN));

    // NoOut while locked
    n_vld = 0;
    npc_type = NOOUT;
    cycle(); cycle();
    check_val("tp6_valid", 32'(state_valid), 32'(0));
    check_val("tp6_meas",  32'(tdead_meas),  32'(0));
    check_val("tp6_comm",  32'(comm_cnt),    32'(0));
    check_val("tp6_npc",   32'(state_npc),   32'(0));
    check_val("tp6_nvld",  32'(n_vld),       32'(0));

    // reset mid-DEAD
    npc_type = ANPC;
    hold(6'b100011, 10);
    hold(6'b000000, 8);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_val("tp6_rst_valid", 32'(state_valid), 32'(0));
    check_val("tp6_rst_comm",  32'(comm_cnt),    32'(0));
    n_vld = 0;
    hold(6'b010010, 10);
    check_val("tp6_rst_nvld", 32'(n_vld), 32'(0));

    // randomized segments
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 99) < 4) npc_type = _npctypes_t'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 10) tdelay_min = 8'($urandom_range(0, 20));
      r = $urandom_range(0, 99);
      t = int'(npc_type);
      if (r < 40) begin
        if (t == 3) code = anpc_tab[$urandom_range(0, 5)];
        else code = {2'($urandom_range(0, 3)), npc_tab[$urandom_range(0, 2)]};
        len = $urandom_range(1, 20);
      end else if (r < 75) begin
        code = (t == 3) ? 6'd0 : {2'($urandom_range(0, 3)), 4'd0};
        len = ($urandom_range(0, 19) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 30);
      end else if (r < 80) begin
        code = 6'($urandom_range(0, 63));
        len = $urandom_range(4, 12);
      end else begin
        code = 6'($urandom_range(0, 63));
        len = $urandom_range(1, 3);
      end
      g_fb = code;
      for (int k = 0; k < len; k++) begin
        fault_clr = ($urandom_range(0, 29) == 0);
        cycle();
      end
      fault_clr = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
